approx_add_sched: RTL and testbench

- Time-shares one 16-bit speculative-carry adder among NREQ requesters (RBM weight/energy accumulation lanes) with round-robin arbitration.
- Per request, the requester selects one of two modes:
  - Approximate: single pass; carry-in of the high byte is predicted as A[0].
  - Exact: the block detects a carry misprediction and spends one extra cycle recomputing the high byte with the true carry.
- Keeps a saturating misprediction counter, used to characterise approximation error.

---
 rtl/approx_add_sched_pkg.sv | 21 ++
 rtl/approx_add_sched_if.sv | 31 +++
 rtl/approx_add_sched_dp.sv | 25 ++
 rtl/approx_add_sched.sv | 147 ++++++++++++++
 tb/tb_approx_add_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_add_sched_pkg.sv
// Shared types and helpers for the time-shared speculative-carry adder.
package approx_add_sched_pkg;

    localparam int DW    = 16;
    localparam int SPLIT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        RESP
    } state_e;

    // The high byte is computed assuming carry-in equals A[0]; a mispredict is when the real low-byte carry differs.
    function automatic logic mispredict(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [SPLIT:0] sl;
        sl = {1'b0, a[SPLIT-1:0]} + {1'b0, b[SPLIT-1:0]};
        return sl[SPLIT] != a[0];
    endfunction

endpackage

// File: rtl/approx_add_sched_if.sv
// Request/response bundle between the requester lanes and the shared adder.
interface approx_add_sched_if #(
    parameter int NREQ = 4
);
    import approx_add_sched_pkg::*;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_exact;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW-1:0]      rsp_sum;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_corrected;
    logic               rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_exact, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_corrected, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_exact, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_corrected, rsp_err
    );

endinterface

// File: rtl/approx_add_sched_dp.sv
// Combinational speculative-carry adder: approximate sum, carry-corrected high byte and mispredict flag.
module approx_add_sched_dp
    import approx_add_sched_pkg::*;
(
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [DW-1:0]    sum_apx,
    output logic [SPLIT-1:0] hi_fix,
    output logic             m
);

    logic [SPLIT:0]   sl;
    logic [SPLIT-1:0] sh;
    logic             c;

    always_comb begin
        sl      = {1'b0, a[SPLIT-1:0]} + {1'b0, b[SPLIT-1:0]};
        c       = sl[SPLIT];
        sh      = a[DW-1:SPLIT] + b[DW-1:SPLIT] + {{(SPLIT-1){1'b0}}, a[0]};
        hi_fix  = a[DW-1:SPLIT] + b[DW-1:SPLIT] + {{(SPLIT-1){1'b0}}, c};
        sum_apx = {sh, sl[SPLIT-1:0]};
        m       = mispredict(a, b);
    end

endmodule

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one speculative-carry adder among NREQ lanes,
// with optional exact-mode correction and a saturating mispredict counter.
module approx_add_sched
    import approx_add_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    approx_add_sched_if.slave   bus,
    output logic [CNTW-1:0]     err_cnt,
    input  logic                cnt_clr,
    output logic                busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            exact_q, exact_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic            m_q, m_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic            gnt_any;

    logic [DW-1:0]    dp_sum;
    logic [SPLIT-1:0] dp_hi;
    logic             dp_m;

    approx_add_sched_dp u_dp (
        .a       (a_q),
        .b       (b_q),
        .sum_apx (dp_sum),
        .hi_fix  (dp_hi),
        .m       (dp_m)
    );

    // Scan upward from rr_q, wrapping, for the first valid requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDW'((32'(rr_q) + off) % NREQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && gnt_any) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        exact_d = exact_q;
        sum_d   = sum_q;
        m_d     = m_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    rr_d    = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    id_d    = gnt_idx;
                    a_d     = bus.req_a[DW*gnt_idx +: DW];
                    b_d     = bus.req_b[DW*gnt_idx +: DW];
                    exact_d = bus.req_exact[gnt_idx];
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = dp_sum;
                m_d     = dp_m;
                state_d = (exact_q && dp_m) ? FIX : RESP;
            end
            FIX: begin
                sum_d   = {dp_hi, sum_q[SPLIT-1:0]};
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-cycle increment.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (state_q == CALC && dp_m && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            exact_q <= 1'b0;
            sum_q   <= '0;
            m_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exact_q <= exact_d;
            sum_q   <= sum_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.rsp_valid     = (state_q == RESP);
        bus.rsp_sum       = sum_q;
        bus.rsp_id        = id_q;
        bus.rsp_corrected = (state_q == RESP) && exact_q && m_q;
        bus.rsp_err       = (state_q == RESP) && !exact_q && m_q;
        busy              = (state_q != IDLE);
        err_cnt           = cnt_q;
    end

endmodule

// File: tb/tb_approx_add_sched.sv
// Self-checking bench for approx_add_sched: directed vectors, arbitration,
// backpressure/reset, counter saturation and randomized traffic vs. an arithmetic model.
`timescale 1ns/1ps
module tb_approx_add_sched;

    localparam int NREQ = 4;
    localparam int CNTW = 4;
    localparam int unsigned CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cnt_clr = 1'b0;
    logic            busy;
    logic [CNTW-1:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int unsigned exp_cnt = 0;
    int unsigned rr_m = 0;

    approx_add_sched_if #(.NREQ(NREQ)) bus ();

    approx_add_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt),
        .cnt_clr (cnt_clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ex;
        logic [15:0] sum;
        logic        err;
        logic        corr;
        int          lat;
        int          cnt;
    } vec_t;

    vec_t vecs[9];

    // Reference arithmetic: true sum is (a+b) mod 2^16; the approximate result
    // is off by (predicted carry - real carry) * 256 in the high byte.
    function automatic int unsigned model_c(input logic [15:0] a, input logic [15:0] b);
        return (((int'(a) % 256) + (int'(b) % 256)) >= 256) ? 1 : 0;
    endfunction

    function automatic bit model_m(input logic [15:0] a, input logic [15:0] b);
        return model_c(a, b) != (int'(a) % 2);
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b, input logic ex);
        int unsigned tru, c, p;
        tru = (int'(a) + int'(b)) % 65536;
        c   = model_c(a, b);
        p   = int'(a) % 2;
        if (ex || c == p) return 16'(tru);
        return 16'((tru + 65536 + p * 256 - c * 256) % 65536);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bump_cnt(input bit m);
        if (m && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        cnt_clr       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        rr_m    = 0;
        @(negedge clk);
    endtask

    // Called on a negedge in IDLE; returns on the negedge right after the handshake edge.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic ex);
        int n;
        bus.req_a[16*id +: 16] = a;
        bus.req_b[16*id +: 16] = b;
        bus.req_exact[id]      = ex;
        bus.req_valid[id]      = 1'b1;
        n = 0;
        #1;
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready[id]) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: id %0d got no ready expected ready", id);
        end
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask

    // Latency counts the handshake cycle, so a plain pass reports 2.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid");
        end
    endtask

    task automatic collect(input int delay);
        repeat (delay) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] hold_sum;
        logic [1:0]  hold_id;
        bit          pend[NREQ];
        logic [15:0] pa[NREQ];
        logic [15:0] pb[NREQ];
        logic        pex[NREQ];
        int          g;
        bit          any;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 2, 0};
        vecs[1] = '{16'h0001, 16'h0000, 1'b0, 16'h0101, 1'b1, 1'b0, 2, 1};
        vecs[2] = '{16'h0080, 16'h0080, 1'b1, 16'h0100, 1'b0, 1'b1, 3, 2};
        vecs[3] = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 3};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 2, 3};
        vecs[5] = '{16'hFF01, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 2, 3};
        vecs[6] = '{16'h1235, 16'h0010, 1'b1, 16'h1245, 1'b0, 1'b1, 3, 4};
        vecs[7] = '{16'h1235, 16'h0010, 1'b0, 16'h1345, 1'b1, 1'b0, 2, 5};
        vecs[8] = '{16'hFFFE, 16'h0003, 1'b0, 16'hFF01, 1'b1, 1'b0, 2, 6};

        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_exact = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_sum",   32'(bus.rsp_sum), 0);
        chk("rst_rsp_id",    32'(bus.rsp_id), 0);
        chk("rst_corr_err",  32'({bus.rsp_corrected, bus.rsp_err}), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_err_cnt",   32'(err_cnt), 0);
        do_reset();

        // Directed vectors, all on requester 0.
        for (int i = 0; i < 9; i++) begin
            issue(0, vecs[i].a, vecs[i].b, vecs[i].ex);
            wait_rsp(lat);
            chk($sformatf("vec%0d_sum", i),  32'(bus.rsp_sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_err", i),  32'(bus.rsp_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_corr", i), 32'(bus.rsp_corrected), 32'(vecs[i].corr));
            chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_id", i),   32'(bus.rsp_id), 0);
            chk($sformatf("vec%0d_cnt", i),  32'(err_cnt), 32'(vecs[i].cnt));
            collect(0);
        end

        // All four requesters valid continuously from reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pa[i]  = 16'($urandom);
            pb[i]  = 16'($urandom);
            pex[i] = 1'($urandom);
            bus.req_a[16*i +: 16] = pa[i];
            bus.req_b[16*i +: 16] = pb[i];
            bus.req_exact[i]      = pex[i];
        end
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(lat);
            chk($sformatf("rr%0d_id", k),  32'(bus.rsp_id), 32'(k % NREQ));
            chk($sformatf("rr%0d_sum", k), 32'(bus.rsp_sum), 32'(model_sum(pa[k % NREQ], pb[k % NREQ], pex[k % NREQ])));
            chk($sformatf("rr%0d_noready", k), 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);

        // Backpressure, then reset in the middle of RESP.
        do_reset();
        issue(2, 16'h3456, 16'h1111, 1'b0);
        bus.req_a[15:0]  = 16'h0102;
        bus.req_b[15:0]  = 16'h0304;
        bus.req_exact[0] = 1'b0;
        bus.req_valid[0] = 1'b1;
        wait_rsp(lat);
        hold_sum = bus.rsp_sum;
        hold_id  = bus.rsp_id;
        chk("bp_id",  32'(hold_id), 2);
        chk("bp_sum", 32'(hold_sum), 32'(model_sum(16'h3456, 16'h1111, 1'b0)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid), 1);
            chk($sformatf("bp%0d_sum", k),   32'(bus.rsp_sum), 32'(hold_sum));
            chk($sformatf("bp%0d_id", k),    32'(bus.rsp_id), 32'(hold_id));
            chk($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 0);
        end
        rst_n = 1'b0;
        bus.req_a[63:48]  = 16'h0F0F;
        bus.req_b[63:48]  = 16'h0101;
        bus.req_exact[3]  = 1'b0;
        bus.req_valid[3]  = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_sum",   32'(bus.rsp_sum), 0);
        chk("mid_rst_id",    32'(bus.rsp_id), 0);
        chk("mid_rst_flags", 32'({bus.rsp_corrected, bus.rsp_err}), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_rsp(lat);
        chk("post_rst_id",  32'(bus.rsp_id), 0);
        chk("post_rst_sum", 32'(bus.rsp_sum), 32'(model_sum(16'h0102, 16'h0304, 1'b0)));
        collect(0);
        #1;
        chk("post_rst_next_grant", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        @(negedge clk);

        // Counter saturation and clear priority.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            issue(0, 16'h0001, 16'h0000, 1'b0);
            wait_rsp(lat);
            bump_cnt(model_m(16'h0001, 16'h0000));
            chk($sformatf("sat%0d_cnt", k), 32'(err_cnt), 32'(exp_cnt));
            collect(0);
        end
        chk("sat_all_ones", 32'(err_cnt), 32'(CNT_MAX));
        issue(0, 16'h0001, 16'h0000, 1'b0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_vs_inc", 32'(err_cnt), 0);
        wait_rsp(lat);
        collect(0);
        issue(0, 16'h0001, 16'h0000, 1'b0);
        wait_rsp(lat);
        chk("cnt_after_clr", 32'(err_cnt), 1);
        collect(0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_idle", 32'(err_cnt), 0);

        // Randomized traffic with held pending requests and a modelled rr pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = 16'($urandom);
                    pb[i]   = 16'($urandom);
                    pex[i]  = 1'($urandom);
                end
                any |= pend[i];
            end
            if (!any) begin
                g       = int'($urandom_range(0, NREQ - 1));
                pend[g] = 1'b1;
                pa[g]   = 16'($urandom);
                pb[g]   = 16'($urandom);
                pex[g]  = 1'($urandom);
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.req_a[16*i +: 16] = pa[i];
                bus.req_b[16*i +: 16] = pb[i];
                bus.req_exact[i]      = pex[i];
                bus.req_valid[i]      = pend[i];
            end
            g = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (g < 0 && pend[(int'(rr_m) + off) % NREQ]) g = (int'(rr_m) + off) % NREQ;
            end
            #1;
            chk($sformatf("rnd%0d_grant", t), 32'(bus.req_ready), 32'(1 << g));
            @(negedge clk);
            pend[g]          = 1'b0;
            bus.req_valid[g] = 1'b0;
            rr_m             = (g + 1) % NREQ;
            wait_rsp(lat);
            bump_cnt(model_m(pa[g], pb[g]));
            chk($sformatf("rnd%0d_id", t),  32'(bus.rsp_id), 32'(g));
            chk($sformatf("rnd%0d_sum", t), 32'(bus.rsp_sum), 32'(model_sum(pa[g], pb[g], pex[g])));
            chk($sformatf("rnd%0d_err", t), 32'(bus.rsp_err), 32'(!pex[g] && model_sum(pa[g], pb[g], 1'b0) != model_sum(pa[g], pb[g], 1'b1)));
            chk($sformatf("rnd%0d_corr", t), 32'(bus.rsp_corrected), 32'(pex[g] && model_m(pa[g], pb[g])));
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'((pex[g] && model_m(pa[g], pb[g])) ? 3 : 2));
            chk($sformatf("rnd%0d_cnt", t), 32'(err_cnt), 32'(exp_cnt));
            chk($sformatf("rnd%0d_noready", t), 32'(bus.req_ready), 0);
            collect(int'($urandom_range(0, 2)));
        end
        bus.req_valid = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
